// File: rtl/vec_seq_ctrl_pkg.sv
// ============================================================================
// vec_seq_pkg : shared types for the vector sequencer (op/state enums, defaults)
// Rev 1.0
// ============================================================================
`default_nettype none

package vec_seq_pkg;

  localparam int VLEN_DEF   = 4;
  localparam int ELEM_W_DEF = 16;
  localparam int EIDX_W_DEF = 2;

  typedef enum logic [2:0] {
    OP_VADD = 3'd0,
    OP_VSUB = 3'd1,
    OP_VMUL = 3'd2,
    OP_VDIV = 3'd3,
    OP_VDOT = 3'd4,
    OP_VLD  = 3'd5,
    OP_VST  = 3'd6,
    OP_ILL  = 3'd7
  } vop_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALU   = 3'd1,
    ST_MREQ  = 3'd2,
    ST_MWAIT = 3'd3,
    ST_DOTWB = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic is_legal(input vop_e op);
`ifdef VSEQ_DIV_EN
    return (op != OP_ILL);
`else
    return (op != OP_ILL) && (op != OP_VDIV);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_seq_ctrl_alu.sv
// ============================================================================
// vec_elem_alu : combinational element ALU (add/sub/mul/div, product for VDOT)
// Rev 1.0 ; divide path present only when VSEQ_DIV_EN is defined
// ============================================================================
`default_nettype none

module vec_elem_alu
  import vec_seq_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  vop_e              op_i,
  input  logic [ELEM_W-1:0] a_i,
  input  logic [ELEM_W-1:0] b_i,
  output logic [ELEM_W-1:0] res_o
);

  logic [ELEM_W-1:0] prod;
  assign prod = a_i * b_i;

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_VADD: res_o = a_i + b_i;
      OP_VSUB: res_o = a_i - b_i;
      OP_VMUL,
      OP_VDOT: res_o = prod;
`ifdef VSEQ_DIV_EN
      OP_VDIV: res_o = (b_i == '0) ? '1 : (a_i / b_i);
`endif
      default: res_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vec_seq_ctrl.sv
// ============================================================================
// vec_seq_ctrl : execute-stage vector sequencer driving vreg/sreg writeback
//                and the shared memory port. Optional VDIV via VSEQ_DIV_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module vec_seq_ctrl
  import vec_seq_pkg::*;
#(
  parameter int VLEN   = VLEN_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int EIDX_W = EIDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [3:0]        va_i,
  input  logic [3:0]        vb_i,
  input  logic [3:0]        vt_i,
  input  logic [15:0]       base_addr_i,
  input  logic              flush_i,
  output logic [3:0]        rd_reg_a_o,
  output logic [3:0]        rd_reg_b_o,
  output logic [EIDX_W-1:0] rd_elem_o,
  input  logic [ELEM_W-1:0] rd_data_a_i,
  input  logic [ELEM_W-1:0] rd_data_b_i,
  output logic              vwr_en_o,
  output logic [3:0]        vwr_reg_o,
  output logic [EIDX_W-1:0] vwr_elem_o,
  output logic [ELEM_W-1:0] vwr_data_o,
  output logic              swr_en_o,
  output logic [ELEM_W-1:0] swr_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [15:0]       mem_addr_o,
  output logic [ELEM_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [ELEM_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              done_o
);

  localparam logic [EIDX_W-1:0] LAST_IDX = EIDX_W'(VLEN - 1);

  state_e              state_q, state_d;
  vop_e                op_q, op_d;
  logic [EIDX_W-1:0]   idx_q, idx_d;
  logic [ELEM_W-1:0]   acc_q, acc_d;
  logic [3:0]          va_q, va_d, vb_q, vb_d, vt_q, vt_d;
  logic [15:0]         base_q, base_d;
  logic [ELEM_W-1:0]   alu_res;
  logic                last;

  assign last = (idx_q == LAST_IDX);

  vec_elem_alu #(.ELEM_W(ELEM_W)) u_alu (
    .op_i  (op_q),
    .a_i   (rd_data_a_i),
    .b_i   (rd_data_b_i),
    .res_o (alu_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_VADD;
      idx_q   <= '0;
      acc_q   <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      vt_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      vt_q    <= vt_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    va_d    = va_q;
    vb_d    = vb_q;
    vt_d    = vt_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          op_d   = vop_e'(op_i);
          va_d   = va_i;
          vb_d   = vb_i;
          vt_d   = vt_i;
          base_d = base_addr_i;
          idx_d  = '0;
          acc_d  = '0;
          if (!is_legal(vop_e'(op_i)))
            state_d = ST_DONE;
          else if (vop_e'(op_i) == OP_VLD || vop_e'(op_i) == OP_VST)
            state_d = ST_MREQ;
          else
            state_d = ST_ALU;
        end
      end
      ST_ALU: begin
        idx_d = idx_q + 1'b1;
        if (op_q == OP_VDOT)
          acc_d = acc_q + alu_res;
        if (last)
          state_d = (op_q == OP_VDOT) ? ST_DOTWB : ST_DONE;
      end
      ST_MREQ: begin
        if (mem_gnt_i) begin
          if (op_q == OP_VST) begin
            idx_d = idx_q + 1'b1;
            if (last)
              state_d = ST_DONE;
          end else begin
            state_d = ST_MWAIT;
          end
        end
      end
      ST_MWAIT: begin
        if (mem_rvalid_i) begin
          if (last) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_MREQ;
          end
        end
      end
      ST_DOTWB: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush_i)
      state_d = ST_IDLE;
  end

  // Every strobe is gated by flush so an aborted cycle leaves no side effect.
  always_comb begin
    rd_reg_a_o  = va_q;
    rd_reg_b_o  = vb_q;
    rd_elem_o   = idx_q;
    vwr_reg_o   = vt_q;
    vwr_elem_o  = idx_q;
    vwr_en_o    = 1'b0;
    vwr_data_o  = '0;
    swr_en_o    = 1'b0;
    swr_data_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    done_o      = 1'b0;
    stall_o     = ((state_q == ST_IDLE) && start_i) ||
                  ((state_q != ST_IDLE) && (state_q != ST_DONE));
    case (state_q)
      ST_ALU: begin
        vwr_en_o   = (op_q != OP_VDOT) && !flush_i;
        vwr_data_o = alu_res;
      end
      ST_MREQ: begin
        mem_req_o   = !flush_i;
        mem_we_o    = (op_q == OP_VST);
        mem_addr_o  = base_q + 16'(idx_q);
        mem_wdata_o = (op_q == OP_VST) ? rd_data_a_i : '0;
      end
      ST_MWAIT: begin
        vwr_en_o   = mem_rvalid_i && !flush_i;
        vwr_data_o = mem_rdata_i;
      end
      ST_DOTWB: begin
        swr_en_o   = !flush_i;
        swr_data_o = acc_q;
      end
      ST_DONE: done_o = !flush_i;
      default: ;
    endcase
  end

endmodule

`default_nettype wire
